lvds_rx_decoder: RTL and testbench

LVDS_RX_DECODER -- requirements
Module: lvds_rx_decoder

---
 rtl/lvds_rx_decoder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_lvds_rx_decoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_decoder.sv
// lvds_rx_decoder: 7:1 serial LVDS receiver that aligns on the sync lane,
// decodes SOF/DATA/IDLE/BLANK sync codes and turns the stream into frame,
// line and pixel events.
//
// Optional build macro: LVDS_RX_PATCHK_EN adds a test-pattern checker
// (outputs pat_err and pat_err_cnt) that expects the Nth pixel of a line to
// carry the value N.
module lvds_rx_decoder #(
    parameter int LOCK_ERR_MAX = 3
) (
    input  logic        lvds_clk,
    input  logic        rst,
    input  logic        sync_in,
    input  logic [1:0]  data_in,
    output logic        locked,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic [13:0] frame_num,
    output logic [13:0] line_num,
    output logic        pix_valid,
    output logic [13:0] pix_data,
    output logic [13:0] line_pix,
    output logic        code_err,
    output logic        seq_err
`ifdef LVDS_RX_PATCHK_EN
    ,
    output logic        pat_err,
    output logic [15:0] pat_err_cnt
`endif
);

    localparam logic [6:0] SYNC_SOF   = 7'b1110100;
    localparam logic [6:0] SYNC_DATA  = 7'b1100100;
    localparam logic [6:0] SYNC_IDLE  = 7'b1100000;
    localparam logic [6:0] SYNC_BLANK = 7'b0000000;

    typedef enum logic {
        LNK_SEARCH = 1'b0,
        LNK_LOCKED = 1'b1
    } link_t;

    typedef enum logic [1:0] {
        DEC_BLANK  = 2'd0,
        DEC_IDLE   = 2'd1,
        DEC_ACTIVE = 2'd2
    } dec_t;

    // Counter saturation helpers.
    function automatic logic [13:0] sat_inc14(input logic [13:0] v);
        return (v == 14'h3FFF) ? v : v + 14'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Input capture and deserialiser state.
    logic        sync_in_q;
    logic [1:0]  data_in_q;
    logic [6:0]  sync_sr_q;
    logic [6:0]  lane0_sr_q;
    logic [6:0]  lane1_sr_q;
    logic [13:0] word;

    // Link / decode control state.
    link_t       link_q, link_d;
    dec_t        dec_q, dec_d;
    logic [2:0]  phase_q, phase_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [13:0] pix_cnt_q, pix_cnt_d;

    // Registered outputs.
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic        line_start_q, line_start_d;
    logic        line_end_q, line_end_d;
    logic        pix_valid_q, pix_valid_d;
    logic        code_err_q, code_err_d;
    logic        seq_err_q, seq_err_d;
    logic [13:0] frame_num_q, frame_num_d;
    logic [13:0] line_num_q, line_num_d;
    logic [13:0] pix_data_q, pix_data_d;
    logic [13:0] line_pix_q, line_pix_d;
`ifdef LVDS_RX_PATCHK_EN
    logic        pat_err_q, pat_err_d;
    logic [15:0] pat_err_cnt_q, pat_err_cnt_d;
`endif

    logic        is_sof;

    assign word = {lane1_sr_q, lane0_sr_q};

    // Sync lane: input flop then shift register; reset so no stale SOF survives.
    always_ff @(posedge lvds_clk or posedge rst) begin
        if (rst) begin
            sync_in_q <= 1'b0;
            sync_sr_q <= '0;
        end else begin
            sync_in_q <= sync_in;
            sync_sr_q <= {sync_sr_q[5:0], sync_in_q};
        end
    end

    // Data lanes: input flop then shift registers; only read when a word is decoded.
    always_ff @(posedge lvds_clk) begin
        data_in_q  <= data_in;
        lane0_sr_q <= {lane0_sr_q[5:0], data_in_q[0]};
        lane1_sr_q <= {lane1_sr_q[5:0], data_in_q[1]};
    end

    // Next-state: word alignment, sync-code decode, event generation.
    always_comb begin
        link_d        = link_q;
        dec_d         = dec_q;
        phase_d       = phase_q;
        err_cnt_d     = err_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        frame_num_d   = frame_num_q;
        line_num_d    = line_num_q;
        pix_data_d    = pix_data_q;
        line_pix_d    = line_pix_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        line_start_d  = 1'b0;
        line_end_d    = 1'b0;
        pix_valid_d   = 1'b0;
        code_err_d    = 1'b0;
        seq_err_d     = 1'b0;
`ifdef LVDS_RX_PATCHK_EN
        pat_err_d     = 1'b0;
        pat_err_cnt_d = pat_err_cnt_q;
`endif
        is_sof        = 1'b0;

        if (link_q == LNK_SEARCH) begin
            // Sliding compare every cycle; a hit fixes the word boundary.
            phase_d = 3'd0;
            if (sync_sr_q == SYNC_SOF) begin
                link_d    = LNK_LOCKED;
                err_cnt_d = '0;
                is_sof    = 1'b1;
            end
        end else begin
            phase_d = (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd6) begin
                case (sync_sr_q)
                    SYNC_SOF: begin
                        err_cnt_d = '0;
                        is_sof    = 1'b1;
                    end
                    SYNC_DATA: begin
                        err_cnt_d = '0;
                        case (dec_q)
                            DEC_IDLE: begin
                                line_start_d = 1'b1;
                                line_num_d   = word;
                                pix_cnt_d    = '0;
                                dec_d        = DEC_ACTIVE;
                            end
                            DEC_ACTIVE: begin
                                pix_valid_d = 1'b1;
                                pix_data_d  = word;
                                pix_cnt_d   = sat_inc14(pix_cnt_q);
`ifdef LVDS_RX_PATCHK_EN
                                if ({1'b0, word} != ({1'b0, pix_cnt_q} + 15'd1)) begin
                                    pat_err_d     = 1'b1;
                                    pat_err_cnt_d = sat_inc16(pat_err_cnt_q);
                                end
`endif
                            end
                            default: seq_err_d = 1'b1;
                        endcase
                    end
                    SYNC_IDLE: begin
                        err_cnt_d = '0;
                        if (dec_q == DEC_ACTIVE) begin
                            line_end_d = 1'b1;
                            line_pix_d = pix_cnt_q;
                        end
                        dec_d = DEC_IDLE;
                    end
                    SYNC_BLANK: begin
                        err_cnt_d = '0;
                        if (dec_q == DEC_ACTIVE) begin
                            line_end_d  = 1'b1;
                            frame_end_d = 1'b1;
                            line_pix_d  = pix_cnt_q;
                        end
                        dec_d = DEC_BLANK;
                    end
                    default: begin
                        // Illegal code: decode state untouched unless lock is lost,
                        // in which case the open line is dropped silently.
                        code_err_d = 1'b1;
                        if (({1'b0, err_cnt_q} + 5'd1) >= 5'(LOCK_ERR_MAX)) begin
                            link_d    = LNK_SEARCH;
                            dec_d     = DEC_BLANK;
                            err_cnt_d = '0;
                            phase_d   = 3'd0;
                        end else begin
                            err_cnt_d = err_cnt_q + 4'd1;
                        end
                    end
                endcase
            end
        end

        if (is_sof) begin
            // SOF inside an open line closes it and flags the sequence break.
            if (dec_q == DEC_ACTIVE) begin
                line_end_d = 1'b1;
                seq_err_d  = 1'b1;
                line_pix_d = pix_cnt_q;
            end
            frame_start_d = 1'b1;
            line_start_d  = 1'b1;
            frame_num_d   = word;
            line_num_d    = '0;
            pix_cnt_d     = '0;
            dec_d         = DEC_ACTIVE;
        end
    end

    // State and output registers.
    always_ff @(posedge lvds_clk or posedge rst) begin
        if (rst) begin
            link_q        <= LNK_SEARCH;
            dec_q         <= DEC_BLANK;
            phase_q       <= '0;
            err_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            line_start_q  <= 1'b0;
            line_end_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            code_err_q    <= 1'b0;
            seq_err_q     <= 1'b0;
            frame_num_q   <= '0;
            line_num_q    <= '0;
            pix_data_q    <= '0;
            line_pix_q    <= '0;
`ifdef LVDS_RX_PATCHK_EN
            pat_err_q     <= 1'b0;
            pat_err_cnt_q <= '0;
`endif
        end else begin
            link_q        <= link_d;
            dec_q         <= dec_d;
            phase_q       <= phase_d;
            err_cnt_q     <= err_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            line_start_q  <= line_start_d;
            line_end_q    <= line_end_d;
            pix_valid_q   <= pix_valid_d;
            code_err_q    <= code_err_d;
            seq_err_q     <= seq_err_d;
            frame_num_q   <= frame_num_d;
            line_num_q    <= line_num_d;
            pix_data_q    <= pix_data_d;
            line_pix_q    <= line_pix_d;
`ifdef LVDS_RX_PATCHK_EN
            pat_err_q     <= pat_err_d;
            pat_err_cnt_q <= pat_err_cnt_d;
`endif
        end
    end

    assign locked      = (link_q == LNK_LOCKED);
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign line_start  = line_start_q;
    assign line_end    = line_end_q;
    assign frame_num   = frame_num_q;
    assign line_num    = line_num_q;
    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign line_pix    = line_pix_q;
    assign code_err    = code_err_q;
    assign seq_err     = seq_err_q;
`ifdef LVDS_RX_PATCHK_EN
    assign pat_err     = pat_err_q;
    assign pat_err_cnt = pat_err_cnt_q;
`endif

endmodule

// File: tb/tb_lvds_rx_decoder.sv
// Bench for lvds_rx_decoder: serialises sync/data words, predicts the event
// stream from a word-level model and compares it with what the DUT emits.
`timescale 1ns/1ps
module tb_lvds_rx_decoder;
    localparam int LOCK_ERR_MAX = 3;
    localparam logic [6:0] C_SOF  = 7'b1110100;
    localparam logic [6:0] C_DATA = 7'b1100100;
    localparam logic [6:0] C_IDLE = 7'b1100000;
    localparam logic [6:0] C_BLK  = 7'b0000000;
    localparam logic [6:0] C_BAD  = 7'b1010101;
    localparam int M_BLK = 0, M_IDL = 1, M_ACT = 2;

    logic        lvds_clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync_in = 1'b0;
    logic [1:0]  data_in = 2'b00;
    logic        locked, frame_start, frame_end, line_start, line_end;
    logic [13:0] frame_num, line_num, pix_data, line_pix;
    logic        pix_valid, code_err, seq_err;
`ifdef LVDS_RX_PATCHK_EN
    logic        pat_err;
    logic [15:0] pat_err_cnt;
`endif

    lvds_rx_decoder #(.LOCK_ERR_MAX(LOCK_ERR_MAX)) dut (
        .lvds_clk(lvds_clk), .rst(rst), .sync_in(sync_in), .data_in(data_in),
        .locked(locked), .frame_start(frame_start), .frame_end(frame_end),
        .line_start(line_start), .line_end(line_end),
        .frame_num(frame_num), .line_num(line_num),
        .pix_valid(pix_valid), .pix_data(pix_data), .line_pix(line_pix),
        .code_err(code_err), .seq_err(seq_err)
`ifdef LVDS_RX_PATCHK_EN
        , .pat_err(pat_err), .pat_err_cnt(pat_err_cnt)
`endif
    );

    always #5 lvds_clk = ~lvds_clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic        lk, fs, fe, ls, le, pv, ce, se, pe;
        logic [13:0] fn, ln, pd, lp;
        logic [15:0] pc;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    // Word-level reference model state
    bit          m_lock;
    int          m_mode, m_err, m_pix, m_pc;
    logic [13:0] m_fn, m_ln, m_pd, m_lp;

    // Event monitor: log every cycle that carries a pulse
    always @(posedge lvds_clk) begin
        ev_t e;
        cyc = cyc + 1;
        #1;
        e = '0;
        e.cyc = cyc;
        e.lk = locked; e.fs = frame_start; e.fe = frame_end; e.ls = line_start;
        e.le = line_end; e.pv = pix_valid; e.ce = code_err; e.se = seq_err;
        e.fn = frame_num; e.ln = line_num; e.pd = pix_data; e.lp = line_pix;
`ifdef LVDS_RX_PATCHK_EN
        e.pe = pat_err; e.pc = pat_err_cnt;
`endif
        if (e.fs | e.fe | e.ls | e.le | e.pv | e.ce | e.se | e.pe) got_q.push_back(e);
    end

    task automatic m_reset();
        m_lock = 0; m_mode = M_BLK; m_err = 0; m_pix = 0; m_pc = 0;
        m_fn = 0; m_ln = 0; m_pd = 0; m_lp = 0;
        exp_q.delete();
    endtask

    // Apply one whole word to the model; expected pulses appear at cycle 'at'
    task automatic model_word(input logic [6:0] s, input logic [13:0] d, input int at);
        ev_t e;
        bit legal;
        e = '0;
        e.cyc = at;
        legal = (s == C_SOF) || (s == C_DATA) || (s == C_IDLE) || (s == C_BLK);
        if (!m_lock && s != C_SOF) return;
        m_lock = 1;
        if (legal) m_err = 0;
        if (s == C_SOF) begin
            if (m_mode == M_ACT) begin e.le = 1; e.se = 1; m_lp = 14'(m_pix); end
            e.fs = 1; e.ls = 1; m_fn = d; m_ln = 0; m_pix = 0; m_mode = M_ACT;
        end else if (s == C_DATA) begin
            if (m_mode == M_IDL) begin
                e.ls = 1; m_ln = d; m_pix = 0; m_mode = M_ACT;
            end else if (m_mode == M_ACT) begin
                e.pv = 1; m_pd = d;
`ifdef LVDS_RX_PATCHK_EN
                if (int'(d) != m_pix + 1) begin
                    e.pe = 1;
                    if (m_pc < 65535) m_pc = m_pc + 1;
                end
`endif
                if (m_pix < 16383) m_pix = m_pix + 1;
            end else begin
                e.se = 1;
            end
        end else if (s == C_IDLE) begin
            if (m_mode == M_ACT) begin e.le = 1; m_lp = 14'(m_pix); end
            m_mode = M_IDL;
        end else if (s == C_BLK) begin
            if (m_mode == M_ACT) begin e.le = 1; e.fe = 1; m_lp = 14'(m_pix); end
            m_mode = M_BLK;
        end else begin
            e.ce = 1;
            m_err = m_err + 1;
            if (m_err >= LOCK_ERR_MAX) begin m_lock = 0; m_err = 0; m_mode = M_BLK; end
        end
        e.lk = m_lock; e.fn = m_fn; e.ln = m_ln; e.pd = m_pd; e.lp = m_lp;
        e.pc = 16'(m_pc);
        if (e.fs | e.fe | e.ls | e.le | e.pv | e.ce | e.se | e.pe) exp_q.push_back(e);
    endtask

    // Drive the top nb bits of a word MSB first; at0 = cycle its bit 0 yields events
    task automatic drive_bits(input logic [6:0] s, input logic [13:0] d, input int nb, output int at0);
        at0 = 0;
        for (int b = 6; b >= 7 - nb; b--) begin
            @(negedge lvds_clk);
            sync_in = s[b];
            data_in = {d[7+b], d[b]};
            if (b == 0) at0 = cyc + 3;
        end
    endtask

    task automatic send_word(input logic [6:0] s, input logic [13:0] d);
        int at;
        drive_bits(s, d, 7, at);
        model_word(s, d, at);
    endtask

    task automatic send_filler();
        int at;
        drive_bits(7'd0, 14'd0, $urandom_range(0, 6), at);
    endtask

    task automatic test_reset();
        rst = 1;
        m_reset();
        repeat (3) @(negedge lvds_clk);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked got %b exp 0", locked); else n_pass++;
        n_checks++;
        if ({frame_start, frame_end, line_start, line_end, pix_valid, code_err, seq_err,
             frame_num, line_num, pix_data, line_pix} !== '0)
            $display("FAIL reset_outputs got %h exp 0", {frame_start, frame_end, line_start, line_end,
                     pix_valid, code_err, seq_err, frame_num, line_num, pix_data, line_pix});
        else n_pass++;
`ifdef LVDS_RX_PATCHK_EN
        n_checks++;
        if ({pat_err, pat_err_cnt} !== '0) $display("FAIL reset_pat got %h exp 0", {pat_err, pat_err_cnt});
        else n_pass++;
`endif
        rst = 0;
        got_q.delete();
    endtask

    task automatic test_lock();
        send_filler();
        send_word(C_SOF, 14'd5);
        send_word(C_IDLE, $urandom_range(0, 16383));
        send_word(C_IDLE, 14'd0);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL lock_locked got %b exp 1", locked); else n_pass++;
        n_checks++;
        if (frame_num !== 14'd5) $display("FAIL lock_frame_num got %0d exp 5", frame_num); else n_pass++;
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL lock_evcount got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL lock_ev[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_line();
        send_word(C_DATA, 14'd7);
        for (int p = 1; p <= 639; p++) send_word(C_DATA, 14'(p));
        send_word(C_IDLE, 14'd0);
        send_word(C_IDLE, 14'd0);
        n_checks++;
        if (line_pix !== 14'd639) $display("FAIL line_pix got %0d exp 639", line_pix); else n_pass++;
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL line_evcount got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL line_ev[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame_random();
        int nl;
        send_word(C_SOF, $urandom_range(0, 16383));
        for (int p = 0; p < int'($urandom_range(0, 10)); p++) send_word(C_DATA, $urandom_range(0, 16383));
        nl = $urandom_range(2, 4);
        for (int l = 0; l < nl; l++) begin
            send_word(C_IDLE, $urandom_range(0, 16383));
            send_word(C_DATA, $urandom_range(0, 16383));
            for (int p = 0; p < int'($urandom_range(0, 12)); p++) send_word(C_DATA, $urandom_range(0, 16383));
        end
        send_word(C_BLK, $urandom_range(0, 16383));
        send_word(C_BLK, 14'd0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL frame_evcount got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL frame_ev[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_seq_err();
        send_word(C_DATA, $urandom_range(0, 16383));
        send_word(C_SOF, $urandom_range(0, 16383));
        send_word(C_DATA, $urandom_range(0, 16383));
        send_word(C_DATA, $urandom_range(0, 16383));
        send_word(C_SOF, $urandom_range(0, 16383));
        send_word(C_DATA, $urandom_range(0, 16383));
        send_word(C_IDLE, 14'd0);
        send_word(C_IDLE, 14'd0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL seq_evcount got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL seq_ev[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_code_err();
        logic [6:0] bad;
        send_word(C_DATA, $urandom_range(0, 16383));
        send_word(C_DATA, $urandom_range(0, 16383));
        for (int k = 0; k < 2; k++) begin
            do bad = 7'($urandom_range(0, 127));
            while (bad == C_SOF || bad == C_DATA || bad == C_IDLE || bad == C_BLK);
            send_word(bad, $urandom_range(0, 16383));
        end
        send_word(C_DATA, $urandom_range(0, 16383));
        for (int k = 0; k < 3; k++) send_word(C_BAD, $urandom_range(0, 16383));
        send_word(C_DATA, $urandom_range(0, 16383));
        n_checks++;
        if (locked !== 1'b0) $display("FAIL codeerr_unlocked got %b exp 0", locked); else n_pass++;
        send_word(C_SOF, $urandom_range(0, 16383));
        send_word(C_IDLE, 14'd0);
        send_word(C_IDLE, 14'd0);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL codeerr_relock got %b exp 1", locked); else n_pass++;
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL codeerr_evcount got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL codeerr_ev[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        int at;
        send_word(C_SOF, $urandom_range(0, 16383));
        for (int p = 0; p < 3; p++) send_word(C_DATA, $urandom_range(0, 16383));
        drive_bits(C_DATA, 14'h1555, 3, at);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL rstmid_pre_evcount got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rstmid_pre_ev[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        rst = 1;
        m_reset();
        repeat (2) @(negedge lvds_clk);
        n_checks++;
        if ({locked, line_pix, pix_data, frame_num} !== '0)
            $display("FAIL rstmid_outputs got %h exp 0", {locked, line_pix, pix_data, frame_num});
        else n_pass++;
        rst = 0;
        got_q.delete();
        send_filler();
        send_word(C_DATA, $urandom_range(0, 16383));
        send_word(C_IDLE, $urandom_range(0, 16383));
        send_word(C_DATA, $urandom_range(0, 16383));
        n_checks++;
        if (locked !== 1'b0) $display("FAIL rstmid_nolock got %b exp 0", locked); else n_pass++;
        send_word(C_SOF, $urandom_range(0, 16383));
        send_word(C_IDLE, 14'd0);
        send_word(C_IDLE, 14'd0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL rstmid_evcount got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rstmid_ev[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

`ifdef LVDS_RX_PATCHK_EN
    task automatic test_patchk();
        rst = 1;
        m_reset();
        repeat (2) @(negedge lvds_clk);
        rst = 0;
        got_q.delete();
        send_filler();
        send_word(C_SOF, 14'd1);
        for (int p = 1; p <= 6; p++) send_word(C_DATA, (p == 3) ? 14'h0100 : 14'(p));
        send_word(C_IDLE, 14'd0);
        send_word(C_IDLE, 14'd0);
        n_checks++;
        if (pat_err_cnt !== 16'd1) $display("FAIL pat_cnt got %0d exp 1", pat_err_cnt); else n_pass++;
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL pat_evcount got %0d exp %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL pat_ev[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_line();
        test_frame_random();
        test_seq_err();
        test_code_err();
        test_reset_midframe();
`ifdef LVDS_RX_PATCHK_EN
        test_patchk();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
